stopwatch_lap: RTL and testbench

Parametrised successor to the team's single-mode 1 kHz stopwatch. It is fully synchronous to clk1k.
- Adds on-chip synchronisation, edge detection and lock-out debounce of both buttons.
- Adds centisecond resolution, a lap-hold display, a clear-when-stopped function and a sticky overflow flag.
- Drives the FND array with packed BCD through disp_val.

---
 rtl/stopwatch_lap.sv | 181 ++++++++++++++++++
 tb/tb_stopwatch_lap.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: 1 kHz stopwatch with synchronised, debounced start/stop and
// lap/clear buttons, centisecond resolution, lap-hold display, clear while
// stopped and a sticky overflow flag. disp_val carries packed BCD mm:ss.cc.
module stopwatch_lap #(
  parameter int TICK_DIV = 10,
  parameter int DEB_CYC  = 20,
  parameter int MAX_MIN  = 59
) (
  input  logic        clk1k,
  input  logic        sw_reset,
  input  logic        sw_strtstop,
  input  logic        sw_lap,
  output logic [31:0] disp_val,
  output logic        running,
  output logic        lap_hold,
  output logic        ovf
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int LW = $clog2(DEB_CYC + 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(DEB_CYC);
  localparam logic [LW-1:0] LOCK_ZERO  = LW'(0);
  localparam logic [6:0]    MIN_LAST   = 7'(MAX_MIN);

  // Binary 0..99 to two packed BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  // [0]=first sync flop, [1]=second sync flop, [2]=previous value
  logic [2:0]    ss_sync_r, lap_sync_r;
  logic [LW-1:0] ss_lock_r, lap_lock_r;
  logic [PW-1:0] presc_r;
  logic [6:0]    cs_r, min_r, snap_cs_r, snap_min_r;
  logic [5:0]    sec_r, snap_sec_r;
  logic          running_r, lap_hold_r, ovf_r;
  logic [31:0]   disp_val_r;

  logic ss_edge_s, lap_edge_s, ss_acc_s, lap_acc_s;
  logic lap_set_s, lap_rel_s, clear_s, tick_s;
  logic [6:0] src_cs_s, src_min_s;
  logic [5:0] src_sec_s;

  // Synchronise both raw buttons and keep the previous synchronised value.
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      ss_sync_r  <= 3'b000;
      lap_sync_r <= 3'b000;
    end else begin
      ss_sync_r  <= {ss_sync_r[1:0], sw_strtstop};
      lap_sync_r <= {lap_sync_r[1:0], sw_lap};
    end
  end

  // Edge detect, lock-out gating and decode of the lap/clear action against the pre-edge state.
  always_comb begin
    ss_edge_s  = ss_sync_r[1] & ~ss_sync_r[2];
    lap_edge_s = lap_sync_r[1] & ~lap_sync_r[2];
    ss_acc_s   = ss_edge_s & (ss_lock_r == LOCK_ZERO);
    lap_acc_s  = lap_edge_s & (lap_lock_r == LOCK_ZERO);
    lap_set_s  = lap_acc_s & running_r & ~lap_hold_r;
    lap_rel_s  = lap_acc_s & lap_hold_r;
    clear_s    = lap_acc_s & ~running_r & ~lap_hold_r;
    tick_s     = running_r & (presc_r == PRESC_LAST);
  end

  // Lock-out counters: reload on an accepted edge, then count down to zero.
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      ss_lock_r  <= LOCK_ZERO;
      lap_lock_r <= LOCK_ZERO;
    end else begin
      if (ss_acc_s) begin
        ss_lock_r <= LOCK_LOAD;
      end else if (ss_lock_r != LOCK_ZERO) begin
        ss_lock_r <= ss_lock_r - LW'(1);
      end else begin
        ss_lock_r <= LOCK_ZERO;
      end
      if (lap_acc_s) begin
        lap_lock_r <= LOCK_LOAD;
      end else if (lap_lock_r != LOCK_ZERO) begin
        lap_lock_r <= lap_lock_r - LW'(1);
      end else begin
        lap_lock_r <= LOCK_ZERO;
      end
    end
  end

  // Run/hold state and the lap snapshot taken on the edge that sets lap_hold.
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      running_r  <= 1'b0;
      lap_hold_r <= 1'b0;
      snap_cs_r  <= 7'd0;
      snap_sec_r <= 6'd0;
      snap_min_r <= 7'd0;
    end else begin
      if (ss_acc_s) running_r <= ~running_r;
      if (lap_set_s) begin
        lap_hold_r <= 1'b1;
        snap_cs_r  <= cs_r;
        snap_sec_r <= sec_r;
        snap_min_r <= min_r;
      end else if (lap_rel_s) begin
        lap_hold_r <= 1'b0;
      end
    end
  end

  // Prescaler and mm:ss.cc counters; clear only happens while stopped so it never meets a tick.
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      presc_r <= PRESC_ZERO;
      cs_r    <= 7'd0;
      sec_r   <= 6'd0;
      min_r   <= 7'd0;
      ovf_r   <= 1'b0;
    end else if (clear_s) begin
      presc_r <= PRESC_ZERO;
      cs_r    <= 7'd0;
      sec_r   <= 6'd0;
      min_r   <= 7'd0;
      ovf_r   <= 1'b0;
    end else if (tick_s) begin
      presc_r <= PRESC_ZERO;
      if (cs_r == 7'd99) begin
        cs_r <= 7'd0;
        if (sec_r == 6'd59) begin
          sec_r <= 6'd0;
          if (min_r == MIN_LAST) begin
            min_r <= 7'd0;
            ovf_r <= 1'b1;
          end else begin
            min_r <= min_r + 7'd1;
          end
        end else begin
          sec_r <= sec_r + 6'd1;
        end
      end else begin
        cs_r <= cs_r + 7'd1;
      end
    end else if (running_r) begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Display source: lap snapshot while holding, otherwise live time.
  always_comb begin
    if (lap_hold_r) begin
      src_cs_s  = snap_cs_r;
      src_sec_s = snap_sec_r;
      src_min_s = snap_min_r;
    end else begin
      src_cs_s  = cs_r;
      src_sec_s = sec_r;
      src_min_s = min_r;
    end
  end

  // Registered BCD display word.
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      disp_val_r <= 32'h0000_0000;
    end else begin
      disp_val_r <= {8'h00, to_bcd(src_min_s), to_bcd({1'b0, src_sec_s}), to_bcd(src_cs_s)};
    end
  end

  assign disp_val = disp_val_r;
  assign running  = running_r;
  assign lap_hold = lap_hold_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap. dut1 runs at TICK_DIV=10; dut2 uses
// TICK_DIV=1 and MAX_MIN=1 so the minute wrap is reachable quickly.
module tb_stopwatch_lap;

  logic        clk1k = 1'b0;
  logic        sw_reset = 1'b0;
  logic        sw_strtstop = 1'b0, sw_lap = 1'b0;
  logic [31:0] disp_val;
  logic        running, lap_hold, ovf;
  logic        b_ss = 1'b0, b_lap = 1'b0;
  logic [31:0] disp2;
  logic        run2, hold2, ovf2;
  int          n_total = 0;
  int          n_pass  = 0;

  stopwatch_lap #(.TICK_DIV(10), .DEB_CYC(20), .MAX_MIN(59)) dut1 (
    .clk1k(clk1k), .sw_reset(sw_reset), .sw_strtstop(sw_strtstop), .sw_lap(sw_lap),
    .disp_val(disp_val), .running(running), .lap_hold(lap_hold), .ovf(ovf));

  stopwatch_lap #(.TICK_DIV(1), .DEB_CYC(4), .MAX_MIN(1)) dut2 (
    .clk1k(clk1k), .sw_reset(sw_reset), .sw_strtstop(b_ss), .sw_lap(b_lap),
    .disp_val(disp2), .running(run2), .lap_hold(hold2), .ovf(ovf2));

  always #5 clk1k = ~clk1k;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk1k);
    #1;
  endtask

  task automatic apply_reset();
    sw_reset = 1'b0;
    sw_strtstop = 1'b0; sw_lap = 1'b0; b_ss = 1'b0; b_lap = 1'b0;
    cyc(3);
    sw_reset = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    sw_reset = 1'b0;
    cyc(3);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== 35'h0) $display("FAIL reset_low: got %h expected %h", {running, lap_hold, ovf, disp_val}, 35'h0);
    else n_pass++;
    sw_reset = 1'b1;
    cyc(2);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== 35'h0) $display("FAIL reset_release: got %h expected %h", {running, lap_hold, ovf, disp_val}, 35'h0);
    else n_pass++;
  endtask

  // Start, run one second, stop, check the value freezes.
  task automatic test_start_stop();
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    cyc(1000);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b100, 32'h0000_0100}) $display("FAIL run_1s: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b100, 32'h0000_0100});
    else n_pass++;
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b000, 32'h0000_0100}) $display("FAIL stop: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b000, 32'h0000_0100});
    else n_pass++;
    cyc(500);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b000, 32'h0000_0100}) $display("FAIL stop_frozen: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b000, 32'h0000_0100});
    else n_pass++;
  endtask

  // Bouncing input gives one toggle; a clean press after lock-out gives the next.
  task automatic test_bounce();
    for (int i = 0; i < 4; i++) begin
      sw_strtstop = 1'b1; cyc(2);
      sw_strtstop = 1'b0; cyc(2);
    end
    cyc(5);
    n_total++;
    if ({running, lap_hold} !== 2'b10) $display("FAIL bounce_one_toggle: got %b expected %b", {running, lap_hold}, 2'b10);
    else n_pass++;
    cyc(23);
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    n_total++;
    if ({running, lap_hold} !== 2'b00) $display("FAIL bounce_next_press: got %b expected %b", {running, lap_hold}, 2'b00);
    else n_pass++;
  endtask

  // Lap freeze at 00:02.37 while counting, release at live 00:05.00.
  task automatic test_lap();
    apply_reset();
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    cyc(2370);
    sw_lap = 1'b1; cyc(5); sw_lap = 1'b0;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b110, 32'h0000_0237}) $display("FAIL lap_freeze: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b110, 32'h0000_0237});
    else n_pass++;
    cyc(300);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b110, 32'h0000_0237}) $display("FAIL lap_held: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b110, 32'h0000_0237});
    else n_pass++;
    cyc(2320);
    sw_lap = 1'b1; cyc(4);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b100, 32'h0000_0500}) $display("FAIL lap_release: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b100, 32'h0000_0500});
    else n_pass++;
    sw_lap = 1'b0; cyc(2);
  endtask

  // Clear while stopped at 00:03.50; lap press while running takes a lap instead.
  task automatic test_clear();
    apply_reset();
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    cyc(3500);
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b000, 32'h0000_0350}) $display("FAIL clear_pre: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b000, 32'h0000_0350});
    else n_pass++;
    sw_lap = 1'b1; cyc(5); sw_lap = 1'b0;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== 35'h0) $display("FAIL clear_stopped: got %h expected %h", {running, lap_hold, ovf, disp_val}, 35'h0);
    else n_pass++;
    cyc(20);
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    cyc(250);
    sw_lap = 1'b1; cyc(5); sw_lap = 1'b0;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b110, 32'h0000_0025}) $display("FAIL clear_running_is_lap: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b110, 32'h0000_0025});
    else n_pass++;
  endtask

  // Wrap past 01:59.99 on dut2 sets ovf, counting continues; clear drops ovf.
  task automatic test_wrap();
    apply_reset();
    b_ss = 1'b1; cyc(5); b_ss = 1'b0;
    cyc(11998);
    n_total++;
    if ({run2, hold2, ovf2, disp2} !== {3'b101, 32'h0001_5999}) $display("FAIL wrap_last: got %h expected %h", {run2, hold2, ovf2, disp2}, {3'b101, 32'h0001_5999});
    else n_pass++;
    cyc(1);
    n_total++;
    if ({run2, hold2, ovf2, disp2} !== {3'b101, 32'h0000_0000}) $display("FAIL wrap_zero: got %h expected %h", {run2, hold2, ovf2, disp2}, {3'b101, 32'h0000_0000});
    else n_pass++;
    cyc(5);
    n_total++;
    if ({run2, hold2, ovf2, disp2} !== {3'b101, 32'h0000_0005}) $display("FAIL wrap_continues: got %h expected %h", {run2, hold2, ovf2, disp2}, {3'b101, 32'h0000_0005});
    else n_pass++;
    b_ss = 1'b1; cyc(5); b_ss = 1'b0;
    n_total++;
    if ({run2, hold2, ovf2, disp2} !== {3'b001, 32'h0000_0009}) $display("FAIL wrap_stop: got %h expected %h", {run2, hold2, ovf2, disp2}, {3'b001, 32'h0000_0009});
    else n_pass++;
    b_lap = 1'b1; cyc(5); b_lap = 1'b0;
    n_total++;
    if ({run2, hold2, ovf2, disp2} !== 35'h0) $display("FAIL wrap_clear_ovf: got %h expected %h", {run2, hold2, ovf2, disp2}, 35'h0);
    else n_pass++;
  endtask

  // Async reset mid-count, pending edge killed by reset, simultaneous start+lap.
  task automatic test_async_and_simul();
    apply_reset();
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    cyc(200);
    sw_reset = 1'b0;
    #1;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== 35'h0) $display("FAIL async_reset_now: got %h expected %h", {running, lap_hold, ovf, disp_val}, 35'h0);
    else n_pass++;
    cyc(2);
    sw_reset = 1'b1;
    cyc(1);
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== 35'h0) $display("FAIL async_reset_after: got %h expected %h", {running, lap_hold, ovf, disp_val}, 35'h0);
    else n_pass++;
    sw_strtstop = 1'b1; cyc(2);
    sw_reset = 1'b0; sw_strtstop = 1'b0;
    cyc(2);
    sw_reset = 1'b1;
    cyc(5);
    n_total++;
    if ({running, lap_hold} !== 2'b00) $display("FAIL pending_pulse_killed: got %b expected %b", {running, lap_hold}, 2'b00);
    else n_pass++;
    sw_strtstop = 1'b1; cyc(5); sw_strtstop = 1'b0;
    cyc(50);
    sw_strtstop = 1'b1; sw_lap = 1'b1; cyc(5);
    sw_strtstop = 1'b0; sw_lap = 1'b0;
    n_total++;
    if ({running, lap_hold, ovf, disp_val} !== {3'b010, 32'h0000_0005}) $display("FAIL simultaneous: got %h expected %h", {running, lap_hold, ovf, disp_val}, {3'b010, 32'h0000_0005});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_bounce();
    test_lap();
    test_clear();
    test_wrap();
    test_async_and_simul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
